// File: rtl/spi_fft_master.sv
// SPI mode-0 master for the audio FFT co-processor: 32 sample words out, a fixed SCLK-idle
// turnaround while the far end computes, then 32 FFT bins back, all under one chip-select.
module spi_fft_master #(
  parameter int CLKS_PER_HALF_BIT = 4,
  parameter int TURNAROUND_CYCLES = 256,
  parameter int NUM_WORDS         = 32
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_L,
  input  logic                       i_Start,
  input  logic                       i_Abort,
  input  logic [NUM_WORDS-1:0][31:0] i_Samples,
  output logic                       o_Busy,
  output logic                       o_Done,
  output logic [NUM_WORDS-1:0][31:0] o_Results,
  output logic                       o_SPI_Clk,
  output logic                       o_SPI_CS_n,
  output logic                       o_SPI_MOSI,
  input  logic                       i_SPI_MISO
);

  localparam int TOTAL_BITS = NUM_WORDS * 32;
  localparam int BIT_W      = $clog2(TOTAL_BITS);
  localparam int CNT_MAX    = (CLKS_PER_HALF_BIT > TURNAROUND_CYCLES) ? CLKS_PER_HALF_BIT
                                                                      : TURNAROUND_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURNAROUND_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(TOTAL_BITS - 1);

  // States: IDLE wait start | TX shift samples | TURN far end computes | RX shift bins | HOLD CS hold
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TX   = 3'd1;
  localparam logic [2:0] S_TURN = 3'd2;
  localparam logic [2:0] S_RX   = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic                       sclk_q, sclk_d;
  logic                       cs_n_q, cs_n_d;
  logic                       mosi_q, mosi_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [TOTAL_BITS-1:0]      tx_sh_q, tx_sh_d;
  logic [TOTAL_BITS-1:0]      rx_sh_q, rx_sh_d;
  logic [NUM_WORDS-1:0][31:0] results_q, results_d;
  logic                       miso_meta_q, miso_sync_q;
  logic                       half_end;

  assign half_end = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    results_d = results_q;

    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          state_d = S_TX;
          for (int i = 0; i < NUM_WORDS; i++) begin
            tx_sh_d[TOTAL_BITS-1-32*i -: 32] = i_Samples[i];
          end
          mosi_d = i_Samples[0][31];
          cs_n_d = 1'b0;
          busy_d = 1'b1;
          sclk_d = 1'b0;
          cnt_d  = HALF_LOAD;
          bit_d  = '0;
        end
      end
      S_TX, S_RX: begin
        if (!half_end) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          cnt_d  = HALF_LOAD;
        end else begin
          // End of a high half: capture (RX), then open the next bit's low half.
          sclk_d = 1'b0;
          cnt_d  = HALF_LOAD;
          if (state_q == S_RX) begin
            rx_sh_d = {rx_sh_q[TOTAL_BITS-2:0], miso_sync_q};
          end
          if (bit_q == LAST_BIT) begin
            mosi_d = 1'b0;
            if (state_q == S_TX) begin
              state_d = S_TURN;
              cnt_d   = TURN_LOAD;
            end else begin
              state_d = S_HOLD;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            if (state_q == S_TX) begin
              tx_sh_d = tx_sh_q << 1;
              mosi_d  = tx_sh_q[TOTAL_BITS-2];
            end
          end
        end
      end
      S_TURN: begin
        if (half_end) begin
          state_d = S_RX;
          cnt_d   = HALF_LOAD;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (half_end) begin
          state_d = S_IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          for (int i = 0; i < NUM_WORDS; i++) begin
            results_d[i] = rx_sh_q[TOTAL_BITS-1-32*i -: 32];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_Abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cs_n_d    = 1'b1;
      sclk_d    = 1'b0;
      mosi_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      results_d = results_q;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      results_q   <= '0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      results_q   <= results_d;
      miso_meta_q <= i_SPI_MISO;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign o_Busy     = busy_q;
  assign o_Done     = done_q;
  assign o_Results  = results_q;
  assign o_SPI_Clk  = sclk_q;
  assign o_SPI_CS_n = cs_n_q;
  assign o_SPI_MOSI = mosi_q;

endmodule

// File: doc/spi_fft_master.md
# spi_fft_master

SPI mode-0 master that drives the audio FFT co-processor link from the host side. On a start request it latches 32 signed 32-bit audio samples and shifts them out MSB-first under one continuous chip-select. It then idles SCLK for a fixed turnaround while the far end computes the FFT, and clocks back 32 × 32-bit FFT bins. It sits between the sample-capture logic and the SPI pins, presenting results as a parallel array with a done pulse.

## Interface
- CLKS_PER_HALF_BIT, 4: i_Clk cycles per SCLK half-period (H); legal range ≥4.
- TURNAROUND_CYCLES, 256: i_Clk cycles (W) with SCLK held low between the TX and RX phases; legal range ≥1.
- NUM_WORDS, 32: 32-bit words per phase; fixed at 32.

- i_Clk  in  1  system clock.
- i_Rst_L  in  1  reset; one clock; reset is synchronous and active-low.
- i_Start  in  1  start request; sampled only in IDLE.
- i_Abort  in  1  abandon transaction; CS released, no done pulse.
- i_Samples  in  32×32  samples to send, word 0 first.
- o_Busy  out  1  high from the cycle after start accept until o_Done or abort.
- o_Done  out  1  one-cycle pulse when o_Results is updated.
- o_Results  out  32×32  received FFT bins, word 0 first.
- o_SPI_Clk  out  1  SCLK, idle low.
- o_SPI_CS_n  out  1  chip select, active low.
- o_SPI_MOSI  out  1  master out.
- i_SPI_MISO  in  1  master in; asynchronous to i_Clk.

## Operation
- States: IDLE, TX, TURN, RX, HOLD.
- IDLE → TX
  - When i_Start = 1.
  - i_Samples copied to the internal TX buffer in the accept cycle.
  - Bit counter cleared.
- TX: 1024 bits.
  - Per word, bits 31..0; words 0..31.
  - Each bit is H cycles SCLK low, then H cycles SCLK high.
  - MOSI changes only while SCLK is low, at the start of each bit's low half.
  - The first bit's low half doubles as CS setup.
- TX → TURN after the last high half. In TURN:
  - SCLK low, MOSI 0, CS_n stays low, for W cycles.
- RX: 1024 bits with the same SCLK shape.
  - MOSI 0.
  - i_SPI_MISO passes a 2-flop synchronizer.
  - The synchronized value is captured on the last i_Clk cycle of each high half.
  - Bits are shifted MSB-first into word 0..31; byte order within a word is [31:24] first.
- RX → HOLD after the last high half. In HOLD:
  - SCLK low, CS_n low, for H cycles.
  - Then CS_n goes high, o_Results is loaded from the RX buffer, o_Done pulses, and the state returns to IDLE.
- i_Abort in any non-IDLE state, next cycle:
  - CS_n = 1, SCLK = 0, MOSI = 0, state IDLE.
  - o_Results unchanged; no o_Done.
- i_Start while busy is ignored.
- i_Start and i_Abort high together in IDLE: start is accepted; abort is a no-op in IDLE.
- CS_n never toggles between TX and RX; the far end must not see CS high before RX completes.

## Timing
- Reset values (synchronous, applied at the clock edge while i_Rst_L = 0):
  - o_SPI_CS_n = 1, o_SPI_Clk = 0, o_SPI_MOSI = 0.
  - o_Busy = 0, o_Done = 0, o_Results all 0.
  - state IDLE.
- Reset mid-transaction behaves as abort, additionally clearing o_Results.
- Start accepted at cycle T:
  - o_Busy = 1 and CS_n = 0 at T+1.
  - MOSI = i_Samples[0][31] at T+1.
- First SCLK rise at T+1+H. Bit k rises at T+1+H+2Hk.
- TX occupies cycles T+1 .. T+2048H.
- RX bit j rises at T+1+2048H+W+H+2Hj.
- CS_n rises, o_Done pulses and o_Busy falls at T+1+4096H+W+H.
  - Defaults: T+16645.
- o_Done is high for exactly one cycle.
- A new i_Start is accepted in the cycle after o_Done, giving ≥1 cycle of CS_n high between transactions.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then idle:
  - Hold i_Rst_L = 0 for 3 cycles → CS_n = 1, SCLK = 0, MOSI = 0, o_Busy = 0, o_Results = 0.
- Single transaction with defaults:
  - i_Samples[i] = 32'hA5000000 + i; loopback model returns word i = 32'h1000_0000 | i.
  - → exactly 2048 SCLK rises.
  - → CS_n low contiguously.
  - → o_Done at T+16645.
  - → o_Results[i] = 32'h1000_0000 | i.
- Bit-level check:
  - Sample 0 = 32'h80000001.
  - → MOSI = 1 at the first SCLK rise, 0 for the next 30 rises, 1 at rise 32.
  - → MOSI stable across every high half.
- Abort mid-TX:
  - Assert i_Abort after 100 SCLK rises.
  - → next cycle CS_n = 1, SCLK = 0, o_Busy = 0.
  - → no o_Done; o_Results retains the prior values.
- Start while busy:
  - Pulse i_Start during RX.
  - → ignored; single o_Done.
  - → back-to-back start the cycle after o_Done is accepted with CS_n high for exactly 1 cycle.
- Parameter sweep:
  - H = 8, W = 1, responder drives MISO = 1 constantly.
  - → all o_Results = 32'hFFFFFFFF.
  - → o_Done at T+1+32768+1+8.
